// File: rtl/wb_data_ram_pkg.sv
// Shared types for the Wishbone data RAM slave.
// Bus widths, FSM state codes and the address-window helper.
package wb_data_ram_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        WB_RAM_IDLE = 2'b00,
        WB_RAM_WAIT = 2'b01,
        WB_RAM_RESP = 2'b10
    } wb_ram_state_t;

    // True when every address bit above the word index and byte
    // offset matches the window base.
    function automatic logic in_window(
        input logic [WB_ADR_W-1:0] adr,
        input logic [WB_ADR_W-1:0] base,
        input int unsigned         aw
    );
        logic [WB_ADR_W-1:0] mask;
        mask = ~((32'h1 << (aw + 2)) - 32'h1);
        return ((adr ^ base) & mask) == '0;
    endfunction

endpackage

// File: rtl/wb_ram_array.sv
// Single-port 2^AW x 32 RAM, per-byte write enables, registered read.
// Ports: clk, en (access strobe), we[3:0] (lane writes), addr, wdata, rdata.
module wb_ram_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_data_ram.sv
// Wishbone B3 classic slave RAM with configurable wait states.
// Ports: clk, rst (sync high), wb_cyc_i/stb_i/we_i/adr_i/sel_i/dat_i in;
// wb_dat_o, wb_ack_o, wb_err_o out. WB_RAM_ERR_EN enables window errors.
module wb_data_ram
    import wb_data_ram_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    wb_ram_state_t state;
    logic [3:0]    cnt;
    logic [31:0]   adr_q;
    logic          we_q;
    logic [3:0]    sel_q;
    logic [31:0]   dat_q;
    logic          ack_q;
    logic          err_q;
    logic          rd_q;

    logic          req;
    logic          go_resp;
    logic [31:0]   cur_adr;
    logic          cur_we;
    logic [3:0]    cur_sel;
    logic [31:0]   cur_dat;
    logic          cur_ok;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [31:0]   ram_rdata;
    logic          unused_adr;

    assign req = wb_cyc_i & wb_stb_i;

    // With zero wait states the access commits straight from the bus,
    // otherwise from the request latched in IDLE.
    always_comb begin
        cur_adr = adr_q;
        cur_we  = we_q;
        cur_sel = sel_q;
        cur_dat = dat_q;
        if (state == WB_RAM_IDLE) begin
            cur_adr = wb_adr_i;
            cur_we  = wb_we_i;
            cur_sel = wb_sel_i;
            cur_dat = wb_dat_i;
        end
    end

`ifdef WB_RAM_ERR_EN
    assign cur_ok = in_window(cur_adr, BASE_ADDR, ADDR_WIDTH);
`else
    assign cur_ok = 1'b1;
`endif

    assign unused_adr = ^{cur_adr, BASE_ADDR};

    always_comb begin
        go_resp = 1'b0;
        unique case (state)
            WB_RAM_IDLE: go_resp = req && (WAIT_STATES == 0);
            WB_RAM_WAIT: go_resp = req && (cnt == 4'd0);
            default:     go_resp = 1'b0;
        endcase
    end

    assign ram_en = go_resp & cur_ok;
    assign ram_we = (ram_en && cur_we) ? cur_sel : 4'b0000;

    wb_ram_array #(
        .AW (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (cur_adr[ADDR_WIDTH+1:2]),
        .wdata (cur_dat),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WB_RAM_IDLE;
            cnt   <= 4'd0;
            adr_q <= '0;
            we_q  <= 1'b0;
            sel_q <= '0;
            dat_q <= '0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state)
                WB_RAM_IDLE: begin
                    if (req) begin
                        adr_q <= wb_adr_i;
                        we_q  <= wb_we_i;
                        sel_q <= wb_sel_i;
                        dat_q <= wb_dat_i;
                        if (go_resp) begin
                            state <= WB_RAM_RESP;
                            ack_q <= cur_ok;
                            err_q <= ~cur_ok;
                            rd_q  <= ~cur_we;
                        end else begin
                            state <= WB_RAM_WAIT;
                            cnt   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                WB_RAM_WAIT: begin
                    if (!req) begin
                        state <= WB_RAM_IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= WB_RAM_RESP;
                        ack_q <= cur_ok;
                        err_q <= ~cur_ok;
                        rd_q  <= ~cur_we;
                    end
                end
                WB_RAM_RESP: begin
                    state <= WB_RAM_IDLE;
                end
                default: begin
                    state <= WB_RAM_IDLE;
                end
            endcase
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = (ack_q && rd_q) ? ram_rdata : 32'h0;

endmodule
